// File: rtl/issue_scheduler.sv
// issue_scheduler
// Pulls one entry per cycle from the issue queue, steers it to the ALU or
// memory pipe, parks a memory op in a one-entry hold register while the
// memory pipe is busy, and generates register wakeups through per-pipe delay
// lines feeding a small wakeup FIFO. Dequeue is throttled so that every
// outstanding wakeup is guaranteed a FIFO slot.
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   IQ_Dequeue_OUT             request an entry from the issue queue
//   IQ_DequeueResult_IN        issue queue returned an entry this cycle
//   IQ_Entry_IN                returned entry
//   IQ_ReadyUpdate_OUT         wakeup strobe
//   IQ_ReadyRegister_OUT       register woken (holds last value when idle)
//   MEM_Busy_IN                memory pipe cannot accept this cycle
//   ALU_Valid_OUT/Entry_OUT    registered issue to ALU pipe
//   MEM_Valid_OUT/Entry_OUT    registered issue to memory pipe
//   IssueCount_OUT             entries issued since reset (wraps)
//
// state    | meaning
// ST_ISSUE | normal dequeue and issue
// ST_HOLD  | memory op parked in hold register, dequeue stalled

module issue_scheduler #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int ALU_LAT       = 1,
    parameter int MEM_LAT       = 3,
    parameter int WQ_DEPTH      = 4,
    localparam int LP           = $clog2(NUM_PHYS_REGS),
    localparam int ENTRY_BITS   = 35 + LP
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic                  IQ_Dequeue_OUT,
    input  logic                  IQ_DequeueResult_IN,
    input  logic [ENTRY_BITS-1:0] IQ_Entry_IN,
    output logic                  IQ_ReadyUpdate_OUT,
    output logic [LP-1:0]         IQ_ReadyRegister_OUT,
    input  logic                  MEM_Busy_IN,
    output logic                  ALU_Valid_OUT,
    output logic [ENTRY_BITS-1:0] ALU_Entry_OUT,
    output logic                  MEM_Valid_OUT,
    output logic [ENTRY_BITS-1:0] MEM_Entry_OUT,
    output logic [31:0]           IssueCount_OUT
);

    localparam int PW      = $clog2(WQ_DEPTH);
    localparam int MR_BIT  = 0;
    localparam int MW_BIT  = 33;
    localparam int DEST_LO = 34;
    localparam int RW_BIT  = 34 + LP;

    typedef enum logic {ST_ISSUE, ST_HOLD} state_t;

    state_t state_q, state_d;
    logic [ENTRY_BITS-1:0] hold_entry;

    logic [ALU_LAT-1:0]         alu_dl_v;
    logic [ALU_LAT-1:0][LP-1:0] alu_dl_d;
    logic [MEM_LAT-1:0]         mem_dl_v;
    logic [MEM_LAT-1:0][LP-1:0] mem_dl_d;

    logic [LP-1:0] wq_mem [WQ_DEPTH];
    logic [PW-1:0] wq_rd, wq_wr;
    logic [PW:0]   wq_count;
    logic [PW+1:0] wq_count_nxt;
    logic [LP-1:0] last_reg;

    logic in_mem, accept, issue_alu, issue_mem, capture_hold;
    logic [ENTRY_BITS-1:0] mem_src;
    int   inflight;
    logic alu_exit, mem_exit;
    logic in0_v, in1_v, push_a, push_b, pop;
    logic [LP-1:0] in0_d, in1_d, da, db, upd_reg;

    // Issue control and hold FSM
    always_comb begin
        state_d  = state_q;
        in_mem   = IQ_Entry_IN[MR_BIT] | IQ_Entry_IN[MW_BIT];

        // Every regwrite op already handed to a pipe but not yet woken counts
        // against the FIFO, including the one sitting at a delay-line exit.
        inflight = int'(ALU_Valid_OUT & ALU_Entry_OUT[RW_BIT])
                 + int'(MEM_Valid_OUT & MEM_Entry_OUT[RW_BIT]);
        for (int i = 0; i < ALU_LAT; i++) inflight += int'(alu_dl_v[i]);
        for (int i = 0; i < MEM_LAT; i++) inflight += int'(mem_dl_v[i]);

        IQ_Dequeue_OUT = !RESET && (state_q == ST_ISSUE)
                       && ((int'(wq_count) + inflight) <= WQ_DEPTH - 2);
        accept       = IQ_Dequeue_OUT && IQ_DequeueResult_IN;
        issue_alu    = accept && !in_mem;
        capture_hold = accept && in_mem && MEM_Busy_IN;
        issue_mem    = !MEM_Busy_IN && ((state_q == ST_HOLD) || (accept && in_mem));
        mem_src      = (state_q == ST_HOLD) ? hold_entry : IQ_Entry_IN;

        case (state_q)
            ST_ISSUE: if (capture_hold) state_d = ST_HOLD;
            ST_HOLD:  if (!MEM_Busy_IN) state_d = ST_ISSUE;
            default:  state_d = ST_ISSUE;
        endcase
    end

    // Wakeup selection: older FIFO contents first, then ALU exit, then MEM exit.
    always_comb begin
        alu_exit = alu_dl_v[ALU_LAT-1];
        mem_exit = mem_dl_v[MEM_LAT-1];
        in0_v    = alu_exit | mem_exit;
        in0_d    = alu_exit ? alu_dl_d[ALU_LAT-1] : mem_dl_d[MEM_LAT-1];
        in1_v    = alu_exit & mem_exit;
        in1_d    = mem_dl_d[MEM_LAT-1];
        if (wq_count != '0) begin
            IQ_ReadyUpdate_OUT = 1'b1;
            upd_reg = wq_mem[wq_rd];
            pop     = 1'b1;
            push_a  = in0_v;
            da      = in0_d;
            push_b  = in1_v;
            db      = in1_d;
        end else begin
            // empty FIFO: the first exit bypasses straight to the output
            IQ_ReadyUpdate_OUT = in0_v;
            upd_reg = in0_d;
            pop     = 1'b0;
            push_a  = in1_v;
            da      = in1_d;
            push_b  = 1'b0;
            db      = in1_d;
        end
        IQ_ReadyRegister_OUT = IQ_ReadyUpdate_OUT ? upd_reg : last_reg;
        wq_count_nxt = (PW+2)'(wq_count) + (PW+2)'(push_a) + (PW+2)'(push_b) - (PW+2)'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= ST_ISSUE;
            hold_entry     <= '0;
            ALU_Valid_OUT  <= 1'b0;
            ALU_Entry_OUT  <= '0;
            MEM_Valid_OUT  <= 1'b0;
            MEM_Entry_OUT  <= '0;
            IssueCount_OUT <= '0;
            alu_dl_v       <= '0;
            alu_dl_d       <= '0;
            mem_dl_v       <= '0;
            mem_dl_d       <= '0;
            wq_rd          <= '0;
            wq_wr          <= '0;
            wq_count       <= '0;
            last_reg       <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) wq_mem[i] <= '0;
        end else begin
            state_q       <= state_d;
            ALU_Valid_OUT <= issue_alu;
            MEM_Valid_OUT <= issue_mem;
            if (issue_alu)    ALU_Entry_OUT <= IQ_Entry_IN;
            if (issue_mem)    MEM_Entry_OUT <= mem_src;
            if (capture_hold) hold_entry    <= IQ_Entry_IN;
            IssueCount_OUT <= IssueCount_OUT + 32'(ALU_Valid_OUT) + 32'(MEM_Valid_OUT);

            alu_dl_v[0] <= ALU_Valid_OUT & ALU_Entry_OUT[RW_BIT];
            alu_dl_d[0] <= ALU_Entry_OUT[DEST_LO +: LP];
            for (int i = 1; i < ALU_LAT; i++) begin
                alu_dl_v[i] <= alu_dl_v[i-1];
                alu_dl_d[i] <= alu_dl_d[i-1];
            end
            mem_dl_v[0] <= MEM_Valid_OUT & MEM_Entry_OUT[RW_BIT];
            mem_dl_d[0] <= MEM_Entry_OUT[DEST_LO +: LP];
            for (int i = 1; i < MEM_LAT; i++) begin
                mem_dl_v[i] <= mem_dl_v[i-1];
                mem_dl_d[i] <= mem_dl_d[i-1];
            end

            if (push_a) wq_mem[wq_wr] <= da;
            if (push_b) wq_mem[wq_wr + PW'(1)] <= db;
            wq_wr    <= wq_wr + PW'(push_a) + PW'(push_b);
            wq_rd    <= wq_rd + PW'(pop);
            wq_count <= wq_count_nxt[PW:0];
            if (IQ_ReadyUpdate_OUT) last_reg <= upd_reg;
        end
    end

    a_wq_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
        int'(wq_count_nxt) <= WQ_DEPTH);

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;

    localparam int LP      = 6;
    localparam int EB      = 35 + LP;
    localparam int ALU_LAT = 1;
    localparam int MEM_LAT = 3;
    localparam int WQD     = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          IQ_Dequeue_OUT;
    logic          IQ_DequeueResult_IN = 1'b0;
    logic [EB-1:0] IQ_Entry_IN = '0;
    logic          IQ_ReadyUpdate_OUT;
    logic [LP-1:0] IQ_ReadyRegister_OUT;
    logic          MEM_Busy_IN = 1'b0;
    logic          ALU_Valid_OUT;
    logic [EB-1:0] ALU_Entry_OUT;
    logic          MEM_Valid_OUT;
    logic [EB-1:0] MEM_Entry_OUT;
    logic [31:0]   IssueCount_OUT;

    issue_scheduler #(
        .NUM_PHYS_REGS(64), .ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT), .WQ_DEPTH(WQD)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .IQ_Dequeue_OUT(IQ_Dequeue_OUT),
        .IQ_DequeueResult_IN(IQ_DequeueResult_IN),
        .IQ_Entry_IN(IQ_Entry_IN),
        .IQ_ReadyUpdate_OUT(IQ_ReadyUpdate_OUT),
        .IQ_ReadyRegister_OUT(IQ_ReadyRegister_OUT),
        .MEM_Busy_IN(MEM_Busy_IN),
        .ALU_Valid_OUT(ALU_Valid_OUT), .ALU_Entry_OUT(ALU_Entry_OUT),
        .MEM_Valid_OUT(MEM_Valid_OUT), .MEM_Entry_OUT(MEM_Entry_OUT),
        .IssueCount_OUT(IssueCount_OUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pending wakeups as (due cycle, pipe, dest) events,
    // an ordered wakeup queue, and the pipe/hold/counter state.
    typedef struct {int due; bit is_mem; int dest;} wk_t;
    wk_t pend[$];
    int  wq[$];
    int  cyc = 0;
    bit  m_alu_v, m_mem_v, m_hold;
    logic [EB-1:0] m_alu_e, m_mem_e, m_hold_e;
    int  m_last;
    logic [31:0] m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [EB-1:0] mk(input bit mr, input bit mw, input bit rw, input int dest);
        logic [EB-1:0] e;
        e = '0;
        e[32:1] = $urandom;
        e[0] = mr;
        e[33] = mw;
        e[34 +: LP] = dest[LP-1:0];
        e[34+LP] = rw;
        return e;
    endfunction

    function automatic bit ism(input logic [EB-1:0] e);
        return e[0] | e[33];
    endfunction

    task automatic step(input bit rst, input bit res, input bit busy, input logic [EB-1:0] ent);
        bit   exp_deq, exp_upd, acc, n_alu, n_mem;
        int   exp_reg;
        @(posedge CLK);
        #1;
        RESET = rst;
        IQ_DequeueResult_IN = res;
        MEM_Busy_IN = busy;
        IQ_Entry_IN = ent;
        #3;
        exp_deq = !rst && !m_hold && ((pend.size() + wq.size()) <= WQD - 2);
        for (int pass = 0; pass < 2; pass++) begin
            int i;
            i = 0;
            while (i < pend.size()) begin
                if (pend[i].due == cyc && int'(pend[i].is_mem) == pass) begin
                    wq.push_back(pend[i].dest);
                    pend.delete(i);
                end else begin
                    i++;
                end
            end
        end
        exp_upd = (wq.size() > 0);
        if (exp_upd) begin
            exp_reg = wq.pop_front();
            m_last  = exp_reg;
        end else begin
            exp_reg = m_last;
        end

        chk("dequeue", 64'(IQ_Dequeue_OUT), 64'(exp_deq));
        chk("alu_valid", 64'(ALU_Valid_OUT), 64'(m_alu_v));
        if (m_alu_v) chk("alu_entry", 64'(ALU_Entry_OUT), 64'(m_alu_e));
        chk("mem_valid", 64'(MEM_Valid_OUT), 64'(m_mem_v));
        if (m_mem_v) chk("mem_entry", 64'(MEM_Entry_OUT), 64'(m_mem_e));
        chk("ready_update", 64'(IQ_ReadyUpdate_OUT), 64'(exp_upd));
        chk("ready_reg", 64'(IQ_ReadyRegister_OUT), 64'(exp_reg));
        chk("issue_count", 64'(IssueCount_OUT), 64'(m_cnt));

        if (rst) begin
            pend.delete();
            wq.delete();
            m_alu_v = 0; m_mem_v = 0; m_hold = 0; m_last = 0; m_cnt = '0;
        end else begin
            m_cnt = m_cnt + 32'(m_alu_v) + 32'(m_mem_v);
            acc   = exp_deq && res;
            n_alu = acc && !ism(ent);
            n_mem = 0;
            if (m_hold) begin
                if (!busy) begin n_mem = 1; m_mem_e = m_hold_e; m_hold = 0; end
            end else if (acc && ism(ent)) begin
                if (busy) begin m_hold = 1; m_hold_e = ent; end
                else begin n_mem = 1; m_mem_e = ent; end
            end
            if (n_alu) m_alu_e = ent;
            m_alu_v = n_alu;
            m_mem_v = n_mem;
            if (n_alu && ent[34+LP])
                pend.push_back('{cyc + 1 + ALU_LAT, 1'b0, int'(ent[34 +: LP])});
            if (n_mem && m_mem_e[34+LP])
                pend.push_back('{cyc + 1 + MEM_LAT, 1'b1, int'(m_mem_e[34 +: LP])});
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0);
    endtask

    logic [EB-1:0] e;
    bit r_rst, r_res, r_busy;
    int kind;

    initial begin
        m_alu_v = 0; m_mem_v = 0; m_hold = 0; m_last = 0; m_cnt = '0;
        m_alu_e = '0; m_mem_e = '0; m_hold_e = '0;
        repeat (2) @(posedge CLK);

        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("rst_alu_valid", 64'(ALU_Valid_OUT), 64'd0);
        chk("rst_mem_valid", 64'(MEM_Valid_OUT), 64'd0);
        chk("rst_ready_update", 64'(IQ_ReadyUpdate_OUT), 64'd0);
        chk("rst_issue_count", 64'(IssueCount_OUT), 64'd0);
        chk("rst_dequeue_after", 64'(IQ_Dequeue_OUT), 64'd1);

        // single ALU op, dest 5
        e = mk(0, 0, 1, 5);
        step(0, 1, 0, e);
        step(0, 0, 0, '0);
        chk("alu5_valid_c1", 64'(ALU_Valid_OUT), 64'd1);
        chk("alu5_entry_c1", 64'(ALU_Entry_OUT), 64'(e));
        step(0, 0, 0, '0);
        chk("alu5_wake_c2", 64'(IQ_ReadyUpdate_OUT), 64'd1);
        chk("alu5_reg_c2", 64'(IQ_ReadyRegister_OUT), 64'd5);
        idle(2);

        // load dest 9 held by busy memory pipe
        e = mk(1, 0, 1, 9);
        step(0, 1, 1, e);
        chk("ld9_deq_c0", 64'(IQ_Dequeue_OUT), 64'd1);
        step(0, 1, 1, '0);
        chk("ld9_deq_c1", 64'(IQ_Dequeue_OUT), 64'd0);
        step(0, 1, 1, '0);
        chk("ld9_deq_c2", 64'(IQ_Dequeue_OUT), 64'd0);
        step(0, 1, 0, '0);
        chk("ld9_deq_c3", 64'(IQ_Dequeue_OUT), 64'd0);
        chk("ld9_memv_c3", 64'(MEM_Valid_OUT), 64'd0);
        step(0, 0, 0, '0);
        chk("ld9_memv_c4", 64'(MEM_Valid_OUT), 64'd1);
        chk("ld9_entry_c4", 64'(MEM_Entry_OUT), 64'(e));
        chk("ld9_deq_c4", 64'(IQ_Dequeue_OUT), 64'd1);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("ld9_nowake_c6", 64'(IQ_ReadyUpdate_OUT), 64'd0);
        step(0, 0, 0, '0);
        chk("ld9_wake_c7", 64'(IQ_ReadyUpdate_OUT), 64'd1);
        chk("ld9_reg_c7", 64'(IQ_ReadyRegister_OUT), 64'd9);
        idle(2);

        // MEM dest 3 and ALU dest 4 collide on the same wakeup cycle
        step(0, 1, 0, mk(1, 0, 1, 3));
        step(0, 0, 0, '0);
        step(0, 1, 0, mk(0, 0, 1, 4));
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("col_wake_c4", 64'(IQ_ReadyUpdate_OUT), 64'd1);
        chk("col_reg4_c4", 64'(IQ_ReadyRegister_OUT), 64'd4);
        step(0, 0, 0, '0);
        chk("col_wake_c5", 64'(IQ_ReadyUpdate_OUT), 64'd1);
        chk("col_reg3_c5", 64'(IQ_ReadyRegister_OUT), 64'd3);
        step(0, 0, 0, '0);
        chk("col_idle_c6", 64'(IQ_ReadyUpdate_OUT), 64'd0);
        chk("col_hold_reg_c6", 64'(IQ_ReadyRegister_OUT), 64'd3);

        // 20 back-to-back ALU regwrite ops
        step(1, 0, 0, '0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, mk(0, 0, 1, i + 10));
            chk("b2b_deq", 64'(IQ_Dequeue_OUT), 64'd1);
        end
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("b2b_count", 64'(IssueCount_OUT), 64'd20);

        // reset right after a MEM issue discards its wakeup
        step(1, 0, 0, '0);
        step(0, 1, 0, mk(1, 0, 1, 7));
        step(1, 0, 0, '0);
        chk("rst7_memv_c1", 64'(MEM_Valid_OUT), 64'd1);
        step(0, 0, 0, '0);
        chk("rst7_alu_valid", 64'(ALU_Valid_OUT), 64'd0);
        chk("rst7_mem_valid", 64'(MEM_Valid_OUT), 64'd0);
        chk("rst7_mem_entry", 64'(MEM_Entry_OUT), 64'd0);
        chk("rst7_ready_update", 64'(IQ_ReadyUpdate_OUT), 64'd0);
        chk("rst7_ready_reg", 64'(IQ_ReadyRegister_OUT), 64'd0);
        chk("rst7_issue_count", 64'(IssueCount_OUT), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, '0);
            chk("rst7_no_wake", 64'(IQ_ReadyUpdate_OUT), 64'd0);
        end

        // store: memory issue, never a wakeup
        e = mk(0, 1, 0, 12);
        step(0, 1, 0, e);
        step(0, 0, 0, '0);
        chk("st_memv_c1", 64'(MEM_Valid_OUT), 64'd1);
        chk("st_entry_c1", 64'(MEM_Entry_OUT), 64'(e));
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, '0);
            chk("st_no_wake", 64'(IQ_ReadyUpdate_OUT), 64'd0);
        end

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            r_rst  = ($urandom_range(199) == 0);
            r_res  = ($urandom_range(9) < 8);
            r_busy = ($urandom_range(9) < ((k < 2000) ? 3 : 1));
            kind   = $urandom_range(3);
            e = mk(kind == 1, kind == 2, $urandom_range(3) != 0, $urandom_range(63));
            step(r_rst, r_res, r_busy, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
